// File: rtl/ngs_bus_pkg.sv
// Shared encodings and defaults for the bus-handover blocks.
// Imported by the BUSRQ responder and its helpers.
package ngs_bus_pkg;

    typedef enum logic [2:0] {
        ST_OWN     = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GRANTED = 3'd3,
        ST_RECLAIM = 3'd4
    } bus_state_e;

    localparam int DEF_TURN_CYCLES = 2;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ngs_sync.sv
// Flop-chain synchroniser for asynchronous bus inputs.
// Cleared asynchronously to the inactive (0) level.
module ngs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/busrq_responder.sv
// Responder side of a Z80-style BUSRQ/BUSAK handshake.
// Drains the local master, turns drivers off, then grants the bus.
module busrq_responder
    import ngs_bus_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk_fpga,
    input  logic       rst,
    input  logic       busrq_n,
    output logic       busak_n,
    input  logic       cyc_active,
    output logic       cyc_start_ok,
    output logic       bus_oe,
    output logic       granted,
    output logic [7:0] grant_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_CYCLES - 1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       grant_cnt_q, grant_cnt_d;
    logic             bus_oe_q, bus_oe_d;
    logic             busak_n_q, busak_n_d;
    logic             granted_q, granted_d;
    logic             rq_s;

    ngs_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rq_sync (
        .clk_i(clk_fpga),
        .rst_i(rst),
        .d_i  (~busrq_n),
        .q_o  (rq_s)
    );

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RECLAIM;
            cnt_q       <= '0;
            grant_cnt_q <= '0;
            bus_oe_q    <= 1'b0;
            busak_n_q   <= 1'b1;
            granted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_cnt_q <= grant_cnt_d;
            bus_oe_q    <= bus_oe_d;
            busak_n_q   <= busak_n_d;
            granted_q   <= granted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_cnt_d = grant_cnt_q;
        unique case (state_q)
            ST_OWN: begin
                cnt_d = '0;
                if (rq_s) begin
                    state_d = cyc_active ? ST_DRAIN : ST_RELEASE;
                end
            end
            ST_DRAIN: begin
                cnt_d = '0;
                if (!rq_s) begin
                    state_d = ST_OWN;
                end else if (!cyc_active) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!rq_s) begin
                    state_d = ST_RECLAIM;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_GRANTED;
                    grant_cnt_d = grant_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GRANTED: begin
                if (!rq_s) begin
                    state_d = ST_RECLAIM;
                    cnt_d   = '0;
                end
            end
            ST_RECLAIM: begin
                // A new request waits until the reclaim finishes.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_OWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RECLAIM;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs registered from the next state so they switch with it.
    always_comb begin
        bus_oe_d  = (state_d == ST_OWN) || (state_d == ST_DRAIN);
        busak_n_d = (state_d != ST_GRANTED);
        granted_d = (state_d == ST_GRANTED);
    end

    assign cyc_start_ok = (state_q == ST_OWN) && !rq_s;
    assign bus_oe       = bus_oe_q;
    assign busak_n      = busak_n_q;
    assign granted      = granted_q;
    assign grant_cnt    = grant_cnt_q;

endmodule

// File: doc/busrq_responder.md
Name: busrq_responder

Overview:
- Responder side of the Z80-style BUSRQ/BUSAK handshake.
- Sits in front of an FPGA-local bus master, e.g. the flash programming sequencer, that normally owns the memory bus.
- When an external master pulls busrq_n low, the block:
  - stops the local master from starting new cycles;
  - lets any in-flight cycle finish;
  - turns the bus drivers off;
  - grants the bus with busak_n low.
- It hands the bus back in reverse order.

Parameters:
- SYNC_STAGES, 2, depth of the busrq_n input synchroniser; minimum 2.
- TURN_CYCLES, 2, dead cycles with drivers off before granting and before reclaiming; minimum 1.
- CNT_W, 4, width of the turnaround counter; must hold TURN_CYCLES-1.

Ports:
- clk_fpga  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- busrq_n  in  1  external bus request, active low; asynchronous.
- busak_n  out  1  bus acknowledge, active low; registered.
- cyc_active  in  1  local master has a bus cycle in progress.
- cyc_start_ok  out  1  local master may start a new cycle on this clk_fpga edge.
- bus_oe  out  1  enable for local address/data/control drivers; registered.
- granted  out  1  status, high while in GRANTED; registered.
- grant_cnt  out  8  count of grants issued; wraps modulo 256.

Behaviour:
- Reset (rst high, any time): takes effect immediately; no clock edge needed.
  - state=RECLAIM, cnt=0.
  - busak_n=1, bus_oe=0, granted=0, grant_cnt=0.
  - Synchroniser flops cleared to "no request".
  - After rst falls, the block completes RECLAIM and only then enables the drivers.
- Synchroniser: rq_s = busrq_n inverted through SYNC_STAGES flops.
  - All decisions use rq_s only, never raw busrq_n.
- cyc_start_ok = (state==OWN) && !rq_s.
  - Combinational from registered signals, so it falls in the same cycle rq_s rises.
  - A new local cycle can never race a request.
- States and transitions, evaluated on each clk_fpga edge:
  - OWN: bus_oe=1, busak_n=1.
    - rq_s && cyc_active goes to DRAIN.
    - rq_s && !cyc_active goes to RELEASE.
  - DRAIN: bus_oe=1, waiting for the local cycle to end.
    - !rq_s (request withdrawn) goes to OWN; this check has priority.
    - Otherwise !cyc_active goes to RELEASE.
  - RELEASE: bus_oe=0, cnt counts 0..TURN_CYCLES-1.
    - !rq_s goes to RECLAIM with cnt=0; no grant is issued.
    - Otherwise, at cnt==TURN_CYCLES-1, go to GRANTED: busak_n<=0, granted<=1, grant_cnt+=1.
  - GRANTED: bus_oe=0, busak_n=0.
    - !rq_s goes to RECLAIM with busak_n<=1, granted<=0, cnt=0.
  - RECLAIM: bus_oe=0, busak_n=1, cnt counts 0..TURN_CYCLES-1.
    - At cnt==TURN_CYCLES-1, go to OWN with bus_oe<=1.
    - If rq_s re-asserts here, RECLAIM still completes. OWN then handles the request on the following edge; there is no direct re-grant.
- cnt is cleared on every entry to RELEASE or RECLAIM.
- Latency, idle local master, busrq_n low before sampling edge S1:
  - busak_n falls on edge S(SYNC_STAGES+TURN_CYCLES+1).
  - bus_oe falls TURN_CYCLES edges before busak_n.
- Release latency, busrq_n high before edge R1:
  - busak_n rises on edge R(SYNC_STAGES+1).
  - bus_oe rises TURN_CYCLES edges after busak_n.
- Invariant: bus_oe==1 and busak_n==0 are never true in the same cycle. There is always at least TURN_CYCLES cycles with both high-impedance-safe (bus_oe=0, busak_n=1) on each handover.
- A busrq_n glitch shorter than one clk_fpga period may be missed entirely. That is acceptable; once captured it follows the state machine.

Decomposition:
- Shared package (ngs_bus_pkg) holds:
  - 3-bit state encoding constants: ST_OWN, ST_DRAIN, ST_RELEASE, ST_GRANTED, ST_RECLAIM.
  - Default TURN_CYCLES and SYNC_STAGES constants.
- One sub-module: ngs_sync, a SYNC_STAGES-deep flop chain with asynchronous active-high clear. It is reused elsewhere for other asynchronous bus inputs.

Test Plan:
- Reset release, busrq_n=1: bus_oe=0 and busak_n=1 during rst; bus_oe=1 exactly 2 edges after rst falls; cyc_start_ok=1 once bus_oe=1.
- Idle grant, defaults: busrq_n low before S1 → bus_oe=0 at S3, busak_n=0 at S5, granted=1, grant_cnt=1; cyc_start_ok=0 from S2 onward.
- Busy grant: cyc_active held high until edge S8 → bus_oe stays 1 through S8; bus_oe=0 at S9; busak_n=0 at S11.
- Return: in GRANTED, busrq_n high before R1 → busak_n=1 at R3, bus_oe=1 at R5, cyc_start_ok=1 at R5.
- Withdrawal: busrq_n low for 3 cycles while cyc_active=1 → DRAIN then back to OWN; busak_n never goes low, grant_cnt unchanged, bus_oe stays 1. Repeat during RELEASE → RECLAIM, bus_oe=1 again after 2 edges.
- Mid-grant reset, plus wrap: assert rst while GRANTED → busak_n=1 and bus_oe=0 immediately without a clock edge. Separately, issue 256 grants → grant_cnt returns to 0. Across the whole test the checker asserts !(bus_oe && !busak_n) every cycle.
